// File: rtl/sram_bank_arbiter.sv
// Two-requester (Wishbone / LA) arbiter and strobe sequencer for the
// SRAM bank pair. Optional macro: SRAM_ARB_LA_PRIORITY_EN (LA wins ties).
module sram_bank_arbiter #(
  parameter int          ADDR_W    = 8,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              la_req_i,
  input  logic              la_we_i,
  input  logic              la_bank_i,
  input  logic              la_hi_i,
  input  logic [ADDR_W-1:0] la_addr_i,
  input  logic [31:0]       la_wdata_i,
  output logic              la_ack_o,
  output logic [31:0]       la_rdata_o,
  output logic              m0_csb_o,
  output logic              m1_csb_o,
  output logic              mem_web_o,
  output logic [3:0]        mem_wmask_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_din_o,
  input  logic [63:0]       m0_dout_i,
  input  logic [31:0]       m1_dout_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int CW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  state_t            state_q, state_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic              r_la_q, r_la_n;
  logic              r_bank_q, r_bank_n;
  logic              r_we_q, r_we_n;
  logic              r_hi_q, r_hi_n;
  logic              last_la_q, last_la_n;

  logic              m0_csb_n, m1_csb_n;
  logic              web_n;
  logic [3:0]        wmask_n;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       din_n;
  logic              wbs_ack_n, la_ack_n;
  logic [31:0]       wbs_dat_n, la_rdata_n;

  logic              wb_v, la_v, pick_la;
  logic              g_bank, g_we, g_hi;
  logic [ADDR_W-1:0] g_addr;
  logic [31:0]       g_din;
  logic [3:0]        g_mask;
  logic [31:0]       rd_sel;

  logic              unused_ok;
  assign unused_ok = ^{wbs_adr_i, last_la_q};

  // Request qualification, arbitration and winner field mux
  always_comb begin
    wb_v = wbs_stb_i & wbs_cyc_i &
           (wbs_adr_i[31:16] == BASE_ADDR[31:16]);
    la_v = la_req_i;
`ifdef SRAM_ARB_LA_PRIORITY_EN
    pick_la = la_v;
`else
    pick_la = la_v & (~wb_v | ~last_la_q);
`endif
    g_bank = pick_la ? la_bank_i  : wbs_adr_i[12];
    g_we   = pick_la ? la_we_i    : wbs_we_i;
    g_hi   = pick_la ? la_hi_i    : wbs_adr_i[11];
    g_addr = pick_la ? la_addr_i  : wbs_adr_i[ADDR_W+1:2];
    g_din  = pick_la ? la_wdata_i : wbs_dat_i;
    g_mask = !g_we  ? 4'h0 :
             pick_la ? 4'hF : wbs_sel_i;
    rd_sel = r_bank_q ? m1_dout_i :
             r_hi_q   ? m0_dout_i[63:32] : m0_dout_i[31:0];
  end

  // Next-state and next-output logic
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    r_la_n     = r_la_q;
    r_bank_n   = r_bank_q;
    r_we_n     = r_we_q;
    r_hi_n     = r_hi_q;
    last_la_n  = last_la_q;
    m0_csb_n   = 1'b1;
    m1_csb_n   = 1'b1;
    web_n      = 1'b1;
    wmask_n    = 4'h0;
    addr_n     = mem_addr_o;
    din_n      = mem_din_o;
    wbs_ack_n  = 1'b0;
    la_ack_n   = 1'b0;
    wbs_dat_n  = wbs_dat_o;
    la_rdata_n = la_rdata_o;
    unique case (state_q)
      S_IDLE: begin
        if (wb_v | la_v) begin
          state_n   = S_ISSUE;
          r_la_n    = pick_la;
          last_la_n = pick_la;
          r_bank_n  = g_bank;
          r_we_n    = g_we;
          r_hi_n    = g_hi;
          m0_csb_n  = g_bank;
          m1_csb_n  = ~g_bank;
          web_n     = ~g_we;
          wmask_n   = g_mask;
          addr_n    = g_addr;
          din_n     = g_din;
        end
      end
      S_ISSUE: begin
        if (r_we_q) begin
          state_n   = S_RESP;
          wbs_ack_n = ~r_la_q;
          la_ack_n  = r_la_q;
        end else begin
          state_n = S_WAIT;
          cnt_n   = CW'(RD_LAT);
        end
      end
      S_WAIT: begin
        if (cnt_q == CW'(1)) begin
          state_n   = S_RESP;
          wbs_ack_n = ~r_la_q;
          la_ack_n  = r_la_q;
          if (r_la_q) la_rdata_n = rd_sel;
          else        wbs_dat_n  = rd_sel;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      S_RESP: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State, request register and registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      r_la_q      <= 1'b0;
      r_bank_q    <= 1'b0;
      r_we_q      <= 1'b0;
      r_hi_q      <= 1'b0;
      last_la_q   <= 1'b1;
      m0_csb_o    <= 1'b1;
      m1_csb_o    <= 1'b1;
      mem_web_o   <= 1'b1;
      mem_wmask_o <= 4'h0;
      mem_addr_o  <= '0;
      mem_din_o   <= '0;
      wbs_ack_o   <= 1'b0;
      la_ack_o    <= 1'b0;
      wbs_dat_o   <= '0;
      la_rdata_o  <= '0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      r_la_q      <= r_la_n;
      r_bank_q    <= r_bank_n;
      r_we_q      <= r_we_n;
      r_hi_q      <= r_hi_n;
      last_la_q   <= last_la_n;
      m0_csb_o    <= m0_csb_n;
      m1_csb_o    <= m1_csb_n;
      mem_web_o   <= web_n;
      mem_wmask_o <= wmask_n;
      mem_addr_o  <= addr_n;
      mem_din_o   <= din_n;
      wbs_ack_o   <= wbs_ack_n;
      la_ack_o    <= la_ack_n;
      wbs_dat_o   <= wbs_dat_n;
      la_rdata_o  <= la_rdata_n;
    end
  end

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench for sram_bank_arbiter (RD_LAT = 2).
// Vector table plus reset, window, arbitration and abort sequences.
module tb_sram_bank_arbiter;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        wack;
  logic [31:0] wrd;
  logic        la_req, la_we, la_bank, la_hi;
  logic [7:0]  la_addr;
  logic [31:0] la_wdata;
  logic        la_ack;
  logic [31:0] la_rdata;
  logic        m0_csb, m1_csb, web;
  logic [3:0]  wmask;
  logic [7:0]  maddr;
  logic [31:0] din;
  logic [63:0] m0_dout;
  logic [31:0] m1_dout;

  int checks = 0;
  int failures = 0;
  logic [31:0] wb_exp = 0;
  logic [31:0] la_exp = 0;

  always #5 clk = ~clk;

  sram_bank_arbiter #(
    .ADDR_W(8),
    .RD_LAT(RD_LAT),
    .BASE_ADDR(32'h3000_0000)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i(we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(wack),
    .wbs_dat_o(wrd),
    .la_req_i(la_req),
    .la_we_i(la_we),
    .la_bank_i(la_bank),
    .la_hi_i(la_hi),
    .la_addr_i(la_addr),
    .la_wdata_i(la_wdata),
    .la_ack_o(la_ack),
    .la_rdata_o(la_rdata),
    .m0_csb_o(m0_csb),
    .m1_csb_o(m1_csb),
    .mem_web_o(web),
    .mem_wmask_o(wmask),
    .mem_addr_o(maddr),
    .mem_din_o(din),
    .m0_dout_i(m0_dout),
    .m1_dout_i(m1_dout)
  );

  typedef struct {
    bit          la;
    bit          we;
    bit          bank;
    bit          hi;
    logic [31:0] adr;
    logic [7:0]  la_addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [63:0] m0;
    logic [31:0] m1;
    logic [7:0]  e_addr;
    logic [3:0]  e_mask;
    logic [31:0] e_rdata;
    int          e_n;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stb = 0; cyc = 0; we = 0; sel = 0;
    adr = 0; wdat = 0;
    la_req = 0; la_we = 0; la_bank = 0;
    la_hi = 0; la_addr = 0; la_wdata = 0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    bit got;
    bit bad_csb;
    m0_dout = v.m0;
    m1_dout = v.m1;
    if (v.la) begin
      la_req = 1; la_we = v.we; la_bank = v.bank;
      la_hi = v.hi; la_addr = v.la_addr;
      la_wdata = v.wdata;
    end else begin
      stb = 1; cyc = 1; we = v.we;
      adr = v.adr; sel = v.sel; wdat = v.wdata;
    end
    tick();
    chk({tag, "_m0csb"}, 64'(m0_csb), 64'(v.bank));
    chk({tag, "_m1csb"}, 64'(m1_csb), 64'(!v.bank));
    chk({tag, "_addr"}, 64'(maddr), 64'(v.e_addr));
    chk({tag, "_web"}, 64'(web), 64'(!v.we));
    chk({tag, "_wmask"}, 64'(wmask), 64'(v.e_mask));
    if (v.we) chk({tag, "_din"}, 64'(din), 64'(v.wdata));
    n = 0;
    got = 0;
    bad_csb = 0;
    while (!got && n < 12) begin
      tick();
      n++;
      if (wack || la_ack) got = 1;
      else if (!m0_csb || !m1_csb) bad_csb = 1;
    end
    chk({tag, "_csb_idle"}, 64'(bad_csb), 64'(0));
    chk({tag, "_ack_cyc"}, 64'(n + 1), 64'(v.e_n + 1));
    chk({tag, "_wack"}, 64'(wack), 64'(!v.la));
    chk({tag, "_laack"}, 64'(la_ack), 64'(v.la));
    if (!v.we) begin
      if (v.la) la_exp = v.e_rdata;
      else      wb_exp = v.e_rdata;
    end
    chk({tag, "_wbdat"}, 64'(wrd), 64'(wb_exp));
    chk({tag, "_lardat"}, 64'(la_rdata), 64'(la_exp));
    idle_inputs();
    tick();
    chk({tag, "_ack1cyc"}, 64'({wack, la_ack}), 64'(0));
  endtask

  initial begin
    int k;
    bit bad;
    int order[3];
    int exp_order[3];

    vecs[0] = '{0, 1, 1, 0, 32'h3000_1010, 8'h00, 4'hC,
                32'hDEAD_BEEF, 64'h0, 32'h0,
                8'h04, 4'hC, 32'h0, 1};
    vecs[1] = '{0, 0, 0, 1, 32'h3000_0808, 8'h00, 4'hF,
                32'h0, 64'h1111_2222_3333_4444, 32'h0,
                8'h02, 4'h0, 32'h1111_2222, 1 + RD_LAT};
    vecs[2] = '{0, 0, 0, 0, 32'h3000_0004, 8'h00, 4'hF,
                32'h0, 64'h1111_2222_3333_4444, 32'h0,
                8'h01, 4'h0, 32'h3333_4444, 1 + RD_LAT};
    vecs[3] = '{0, 0, 1, 0, 32'h3000_13FC, 8'h00, 4'hF,
                32'h0, 64'h1111_2222_3333_4444, 32'hCAFE_F00D,
                8'hFF, 4'h0, 32'hCAFE_F00D, 1 + RD_LAT};
    vecs[4] = '{1, 1, 0, 1, 32'h0, 8'h55, 4'h0,
                32'h1234_5678, 64'h0, 32'h0,
                8'h55, 4'hF, 32'h0, 1};
    vecs[5] = '{1, 0, 0, 1, 32'h0, 8'h10, 4'h0,
                32'h0, 64'h1111_2222_3333_4444, 32'h0,
                8'h10, 4'h0, 32'h1111_2222, 1 + RD_LAT};
    vecs[6] = '{1, 0, 1, 0, 32'h0, 8'hAA, 4'h0,
                32'h0, 64'h0, 32'h0BAD_F00D,
                8'hAA, 4'h0, 32'h0BAD_F00D, 1 + RD_LAT};
    vecs[7] = '{0, 1, 0, 1, 32'h3000_0800, 8'h00, 4'h1,
                32'hA5A5_A5A5, 64'h0, 32'h0,
                8'h00, 4'h1, 32'h0, 1};
    vecs[8] = '{1, 0, 0, 0, 32'h0, 8'h7F, 4'h0,
                32'h0, 64'h89AB_CDEF_0123_4567, 32'h0,
                8'h7F, 4'h0, 32'h0123_4567, 1 + RD_LAT};

    idle_inputs();
    m0_dout = 0;
    m1_dout = 0;
    rst = 1;
    la_req = 1;
    stb = 1; cyc = 1; we = 1;
    adr = 32'h3000_1000; sel = 4'hF;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!m0_csb || !m1_csb) bad = 1;
    end
    chk("rst_csb_held", 64'(bad), 64'(0));
    chk("rst_m0csb", 64'(m0_csb), 64'(1));
    chk("rst_m1csb", 64'(m1_csb), 64'(1));
    chk("rst_web", 64'(web), 64'(1));
    chk("rst_wmask", 64'(wmask), 64'(0));
    chk("rst_addr", 64'(maddr), 64'(0));
    chk("rst_din", 64'(din), 64'(0));
    chk("rst_acks", 64'({wack, la_ack}), 64'(0));
    chk("rst_wbdat", 64'(wrd), 64'(0));
    chk("rst_lardat", 64'(la_rdata), 64'(0));
    idle_inputs();
    rst = 0;
    tick();

    for (int i = 0; i < 9; i++)
      run_vec(vecs[i], $sformatf("v%0d", i));

    stb = 1; cyc = 1; we = 0;
    adr = 32'h2000_0000;
    bad = 0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!m0_csb || !m1_csb) bad = 1;
      if (wack || la_ack) k++;
    end
    chk("oow_csb", 64'(bad), 64'(0));
    chk("oow_ack", 64'(k), 64'(0));
    idle_inputs();
    tick();

    m0_dout = 64'h1111_2222_3333_4444;
    stb = 1; cyc = 1; we = 0;
    adr = 32'h3000_0808;
    tick();
    chk("abort_issue", 64'(m0_csb), 64'(0));
    tick();
    rst = 1;
    tick();
    rst = 0;
    idle_inputs();
    wb_exp = 0;
    la_exp = 0;
    chk("abort_csb", 64'({m0_csb, m1_csb}), 64'(3));
    bad = 0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!m0_csb || !m1_csb) bad = 1;
      if (wack || la_ack) k++;
    end
    chk("abort_noack", 64'(k), 64'(0));
    chk("abort_csbhi", 64'(bad), 64'(0));
    chk("abort_wbdat", 64'(wrd), 64'(0));
    run_vec(vecs[6], "post_abort");

    rst = 1;
    tick();
    rst = 0;
    wb_exp = 0;
    la_exp = 0;
    tick();
    stb = 1; cyc = 1; we = 1;
    adr = 32'h3000_1000; sel = 4'hF;
    wdat = 32'h0000_0001;
    la_req = 1; la_we = 1;
    la_bank = 1; la_addr = 8'h01;
    la_wdata = 32'h0000_0002;
    k = 0;
    bad = 0;
    for (int i = 0; i < 40 && k < 3; i++) begin
      tick();
      if (wack && la_ack) bad = 1;
      if (wack) begin
        order[k] = 0;
        k++;
      end else if (la_ack) begin
        order[k] = 1;
        k++;
      end
    end
    idle_inputs();
`ifdef SRAM_ARB_LA_PRIORITY_EN
    exp_order = '{1, 1, 1};
`else
    exp_order = '{0, 1, 0};
`endif
    chk("rr_count", 64'(k), 64'(3));
    chk("rr_dual_ack", 64'(bad), 64'(0));
    if (k == 3) begin
      for (int i = 0; i < 3; i++)
        chk($sformatf("rr_grant%0d", i),
            64'(order[i]), 64'(exp_order[i]));
    end
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_bank_arbiter.md
# sram_bank_arbiter

Sequencing and arbitration controller for the user-project SRAM pair: bank 0 (64-bit-output generic RAM) and bank 1 (sky130 32x256 1rw1r macro, port 0). It shares the single read/write port of each bank between two requesters, the Wishbone slave (WB MI A) and a logic-analyzer-driven request port. It also generates properly timed csb/web/wmask/addr/din strobes and returns read data with a one-cycle acknowledge. It sits between `user_proj_example`-level glue and the two macro instances, replacing direct LA/io_in drive of the chip selects.

## Interface
- `ADDR_W`, 8, word-address width driven to both banks
- `RD_LAT`, 1, cycles (>=1) between the csb-low issue cycle and dout being valid
- `BASE_ADDR`, 32'h3000_0000, Wishbone window; only bits [31:16] are compared
- `wb_clk_i  in  1  single clock; all logic on rising edge`
- `wb_rst_i  in  1  synchronous, active-high reset`
- `wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  Wishbone classic strobe/cycle/write`
- `wbs_sel_i  in  4  byte lanes -> mem_wmask_o on writes`
- `wbs_adr_i  in  32  byte address: [12] bank, [11] bank-0 half select, [ADDR_W+1:2] word`
- `wbs_dat_i  in  32  write data`
- `wbs_ack_o  out  1  one-cycle acknowledge`
- `wbs_dat_o  out  32  read data, valid while wbs_ack_o`
- `la_req_i  in  1  LA request, level, held until la_ack_o`
- `la_we_i, la_bank_i, la_hi_i  in  1  write / bank / bank-0 half select`
- `la_addr_i  in  ADDR_W  word address`
- `la_wdata_i  in  32  write data (wmask forced 4'hF)`
- `la_ack_o  out  1  one-cycle acknowledge`
- `la_rdata_o  out  32  read data, held until next LA read completes`
- `m0_csb_o, m1_csb_o  out  1  active-low chip selects, bank 0 / bank 1`
- `mem_web_o  out  1  active-low write enable, shared`
- `mem_wmask_o  out  4  write mask, shared`
- `mem_addr_o  out  ADDR_W  address, shared`
- `mem_din_o  out  32  write data, shared`
- `m0_dout_i  in  64  bank 0 read data`
- `m1_dout_i  in  32  bank 1 read data`

## Operation
- WB request valid = stb & cyc & (wbs_adr_i[31:16] == BASE_ADDR[31:16]); out-of-window cycles are ignored and never acked.
- FSM IDLE -> ISSUE -> (WAIT, reads only) -> RESP -> IDLE.
- IDLE: arbitrate, latch winner's bank/we/half/addr/data/mask into a request register; enter ISSUE. No request: stay.
- Arbitration: round-robin; `last_grant` flag favours the requester not served last; reset value = LA, so WB wins the first tie.
- ISSUE (1 cycle): selected csb low, other high; web = ~we; wmask = sel (WB) or 4'hF (LA) on writes, 4'h0 on reads. Writes -> RESP; reads -> WAIT.
- WAIT: down-counter loaded with RD_LAT; csb high; on count == 1 capture read data, -> RESP.
- Read data: bank 1 = m1_dout_i; bank 0 = half ? m0_dout_i[63:32] : m0_dout_i[31:0]. Bank-0 writes touch only the 32-bit din path; half bit is ignored on writes.
- RESP (1 cycle): ack of the granted requester high; wbs_dat_o / la_rdata_o updated only for reads; -> IDLE.
- Only one transaction in flight; a requester losing arbitration waits, inputs held.

## Timing
- Reset values: m0_csb_o=1, m1_csb_o=1, mem_web_o=1, mem_wmask_o=0, mem_addr_o=0, mem_din_o=0, wbs_ack_o=0, wbs_dat_o=0, la_ack_o=0, la_rdata_o=0, state IDLE, last_grant=LA.
- All outputs registered; no combinational input-to-output path.
- Request sampled in cycle 0: csb low in cycle 1; write ack in cycle 2; read ack in cycle 2+RD_LAT.
- Ack is exactly one cycle; IDLE after RESP re-samples, so a WB master dropping stb after ack is not re-served.
- Both valid in same IDLE cycle: round-robin (or macro priority) decides; loser served back-to-back next.
- wb_rst_i mid-transaction: immediate return to IDLE next edge, csb high, ack suppressed, transaction dropped.

## Configuration
- `SRAM_ARB_LA_PRIORITY_EN` defined: LA port has fixed priority over WB on every tie; last_grant unused.
- Not defined: round-robin as above.

## Test plan
- Reset with la_req_i=1, stb=1: all outputs at reset values; both csb stay 1 while wb_rst_i=1.
- WB write 0xDEADBEEF to 0x3000_1010, sel=4'hC: m1_csb_o=0 one cycle, addr=4, wmask=4'hC; ack at cycle 2.
- WB read of 0x3000_0808 with m0_dout_i=64'h1111_2222_3333_4444, RD_LAT=2: wbs_dat_o=0x1111_2222, ack at cycle 4.
- WB stb to 0x2000_0000: no csb activity, no ack over 20 cycles.
- WB and LA requesting together three times: grants WB, LA, WB (round-robin); with macro, LA every tie.
- wb_rst_i pulsed in WAIT of a read: no ack, csb high, next request completes normally.
